// File: rtl/cv32e40p_aligner_buf.sv
// cv32e40p_aligner_buf: halfword-granular instruction aligner.
//
// Takes fetch beats of FETCH_WIDTH bits (32 or 64) into a circular buffer of
// BUF_HW halfwords. Each handshake emits one 32-bit or one 16-bit (compressed)
// instruction together with its PC. A branch may target any halfword. The
// halfwords of the first beat that lie before the target are dropped.
//
// Optional build macro: CV32E40P_ALIGNER_BYPASS_EN. When it is defined and the
// buffer is empty, the head is decoded straight from the incoming beat, so a
// fetched instruction can be handed over in the same cycle it arrives.
module cv32e40p_aligner_buf #(
    parameter int FETCH_WIDTH = 32,
    parameter int BUF_HW      = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   fetch_valid_i,
    output logic                   fetch_ready_o,
    input  logic [FETCH_WIDTH-1:0] fetch_rdata_i,
    output logic                   instr_valid_o,
    input  logic                   instr_ready_i,
    output logic [31:0]            instr_aligned_o,
    output logic                   instr_compressed_o,
    output logic [31:0]            pc_o,
    input  logic                   branch_i,
    input  logic [31:0]            branch_addr_i
);

    localparam int HPB = FETCH_WIDTH / 16;
    localparam int PW  = $clog2(BUF_HW);
    localparam int CW  = $clog2(BUF_HW + 1);

    // Halfword storage. It has no reset: count_q alone says which entries
    // hold live data.
    logic [15:0]   hw_q [BUF_HW];
    logic [PW-1:0] rd_q;
    logic [PW-1:0] wr_q;
    logic [CW-1:0] count_q;
    logic [31:0]   pc_q;
    logic [1:0]    skip_q;

    logic [15:0] fetch_hw [HPB];
    logic [1:0]  skip_d;
    logic [PW-1:0] rd_nxt1;
    logic        bypass;
    logic        push;
    logic        pop;
    logic        head_comp;
    logic        head_avail;
    logic [15:0] head_lo;
    logic [15:0] head_hi;
    int          drop;
    int          push_n;
    int          pop_n;
    int          buf_pop_n;

    // Bit 0 of the target is always treated as zero (halfword alignment).
    logic        unused_addr_lsb;
    assign unused_addr_lsb = branch_addr_i[0];

    // Pointer increment modulo BUF_HW. inc never exceeds HPB, and BUF_HW is
    // larger than 2*HPB, so a single conditional subtraction is enough even
    // when the depth is not a power of two.
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int inc);
        int s;
        s = int'(p) + inc;
        if (s >= BUF_HW) begin
            s = s - BUF_HW;
        end
        return PW'(s);
    endfunction

    // The halfword offset of a branch target inside its fetch beat.
    assign skip_d = (HPB == 4) ? branch_addr_i[2:1] : {1'b0, branch_addr_i[1]};

    assign rd_nxt1 = ptr_add(rd_q, 1);

    // Split the incoming beat into halfwords. Halfword 0 is the lowest address.
    always_comb begin
        for (int i = 0; i < HPB; i++) begin
            fetch_hw[i] = fetch_rdata_i[16*i +: 16];
        end
    end

    // Head decode, handshakes and the halfword counts moved this cycle.
    always_comb begin
        bypass = 1'b0;
`ifdef CV32E40P_ALIGNER_BYPASS_EN
        bypass = (count_q == '0) && (skip_q == 2'd0) && !branch_i && fetch_valid_i;
`endif
        head_lo    = bypass ? fetch_hw[0] : hw_q[rd_q];
        head_hi    = bypass ? fetch_hw[1] : hw_q[rd_nxt1];
        head_avail = bypass || (count_q != '0);
        head_comp  = head_lo[1:0] != 2'b11;

        // A 32-bit head whose upper halfword has not arrived yet stays invisible.
        instr_valid_o = !branch_i &&
                        (bypass || ((int'(count_q) >= 1) && head_comp) || (int'(count_q) >= 2));

        // No credit is taken for a pop in the same cycle; only the registered
        // occupancy decides whether a whole beat fits.
        fetch_ready_o = ((int'(count_q) + HPB) <= BUF_HW) && !branch_i;

        push  = fetch_valid_i && fetch_ready_o;
        pop   = instr_valid_o && instr_ready_i;
        pop_n = head_comp ? 1 : 2;

        // The low halfwords of a beat are dropped either because they precede a
        // branch target or because the bypass path already handed them over.
        if (bypass) begin
            drop = pop ? pop_n : 0;
        end else begin
            drop = int'(skip_q);
        end
        push_n    = push ? (HPB - drop) : 0;
        buf_pop_n = (pop && !bypass) ? pop_n : 0;

        instr_aligned_o    = 32'h0;
        if (instr_valid_o) begin
            instr_aligned_o = head_comp ? {16'h0, head_lo} : {head_hi, head_lo};
        end
        instr_compressed_o = head_avail && !branch_i && head_comp;
        pc_o               = pc_q;
    end

    // Control state. A branch overrides any push and pop in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            pc_q    <= 32'h0;
            skip_q  <= 2'd0;
        end else if (branch_i) begin
            count_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            pc_q    <= {branch_addr_i[31:1], 1'b0};
            skip_q  <= skip_d;
        end else begin
            count_q <= CW'(int'(count_q) + push_n - buf_pop_n);
            if (push) begin
                wr_q   <= ptr_add(wr_q, push_n);
                skip_q <= 2'd0;
            end
            if (pop) begin
                pc_q <= pc_q + (head_comp ? 32'd2 : 32'd4);
                if (!bypass) begin
                    rd_q <= ptr_add(rd_q, pop_n);
                end
            end
        end
    end

    // Halfword writes. Dropped halfwords are skipped; the survivors are packed
    // contiguously from the write pointer.
    always_ff @(posedge clk) begin
        for (int i = 0; i < HPB; i++) begin
            if (push && (i >= drop)) begin
                hw_q[ptr_add(wr_q, i - drop)] <= fetch_hw[i];
            end
        end
    end

endmodule

// File: tb/tb_cv32e40p_aligner_buf.sv
// Bench for cv32e40p_aligner_buf. Two instances are used: a 32-bit fetch with
// BUF_HW=6 (index 0) and a 64-bit fetch with BUF_HW=9 (index 1). A
// halfword-stream reference model predicts the outputs of each instance.
module tb_cv32e40p_aligner_buf;

    logic        clk;
    logic        rst_s [2];
    logic        fv_s  [2];
    logic [63:0] fd_s  [2];
    logic        ir_s  [2];
    logic        br_s  [2];
    logic [31:0] ba_s  [2];

    logic        rdy [2];
    logic        vld [2];
    logic [31:0] ins [2];
    logic        cmp [2];
    logic [31:0] pco [2];

    int n_chk;
    int n_pass;
    int check_en;

    // Reference model: the ordered list of halfwords that are waiting to be
    // delivered, the PC of the first one, and the pending branch offset.
    logic [15:0] mq    [2][32];
    int          mn    [2];
    logic [31:0] mpc   [2];
    int          mskip [2];

    cv32e40p_aligner_buf #(.FETCH_WIDTH(32), .BUF_HW(6)) u_dut32 (
        .clk               (clk),
        .rst_n             (rst_s[0]),
        .fetch_valid_i     (fv_s[0]),
        .fetch_ready_o     (rdy[0]),
        .fetch_rdata_i     (fd_s[0][31:0]),
        .instr_valid_o     (vld[0]),
        .instr_ready_i     (ir_s[0]),
        .instr_aligned_o   (ins[0]),
        .instr_compressed_o(cmp[0]),
        .pc_o              (pco[0]),
        .branch_i          (br_s[0]),
        .branch_addr_i     (ba_s[0])
    );

    cv32e40p_aligner_buf #(.FETCH_WIDTH(64), .BUF_HW(9)) u_dut64 (
        .clk               (clk),
        .rst_n             (rst_s[1]),
        .fetch_valid_i     (fv_s[1]),
        .fetch_ready_o     (rdy[1]),
        .fetch_rdata_i     (fd_s[1]),
        .instr_valid_o     (vld[1]),
        .instr_ready_i     (ir_s[1]),
        .instr_aligned_o   (ins[1]),
        .instr_compressed_o(cmp[1]),
        .pc_o              (pco[1]),
        .branch_i          (br_s[1]),
        .branch_addr_i     (ba_s[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input int k, input logic r, input logic fv, input logic [63:0] fd,
                         input logic ir, input logic br, input logic [31:0] ba);
        rst_s[k] = r;
        fv_s[k]  = fv;
        fd_s[k]  = fd;
        ir_s[k]  = ir;
        br_s[k]  = br;
        ba_s[k]  = ba;
    endtask

    task automatic idle_all();
        for (int k = 0; k < 2; k++) drive(k, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 32'h0);
    endtask

    // Compare one instance against the model, then advance the model past the clock edge.
    task automatic eval_k(input int k);
        int          hpb;
        int          bh;
        int          len;
        int          kk;
        logic [15:0] fh [4];
        logic [15:0] v0;
        logic [15:0] v1;
        logic        byp;
        logic        comp;
        logic        ev;
        logic        er;
        logic        push;
        logic        pop;
        hpb = (k == 0) ? 2 : 4;
        bh  = (k == 0) ? 6 : 9;
        for (int i = 0; i < 4; i++) fh[i] = fd_s[k][16*i +: 16];
        byp = 1'b0;
`ifdef CV32E40P_ALIGNER_BYPASS_EN
        byp = (mn[k] == 0) && (mskip[k] == 0) && !br_s[k] && fv_s[k];
`endif
        if (byp) begin
            len = hpb;
            v0  = fh[0];
            v1  = fh[1];
        end else begin
            len = mn[k];
            v0  = mq[k][0];
            v1  = mq[k][1];
        end
        comp = (len >= 1) && (v0[1:0] != 2'b11);
        ev   = !br_s[k] && (len >= 1) && (comp || (len >= 2));
        er   = ((mn[k] + hpb) <= bh) && !br_s[k];

        if (check_en != 0) begin
            check_eq($sformatf("u%0d fetch_ready", k), 32'(rdy[k]), 32'(er));
            check_eq($sformatf("u%0d instr_valid", k), 32'(vld[k]), 32'(ev));
            check_eq($sformatf("u%0d pc", k), pco[k], mpc[k]);
            if (ev) begin
                check_eq($sformatf("u%0d instr", k), ins[k],
                         comp ? {16'h0, v0} : {v1, v0});
                check_eq($sformatf("u%0d compressed", k), 32'(cmp[k]), 32'(comp));
            end
        end

        if (!rst_s[k]) begin
            mn[k]    = 0;
            mpc[k]   = 32'h0;
            mskip[k] = 0;
        end else if (br_s[k]) begin
            mn[k]    = 0;
            mpc[k]   = {ba_s[k][31:1], 1'b0};
            mskip[k] = int'(ba_s[k][2:1]) % hpb;
        end else begin
            push = fv_s[k] && er;
            pop  = ev && ir_s[k];
            if (push) begin
                for (int i = mskip[k]; i < hpb; i++) begin
                    mq[k][mn[k]] = fh[i];
                    mn[k]++;
                end
                mskip[k] = 0;
            end
            if (pop) begin
                kk = comp ? 1 : 2;
                for (int i = 0; i < mn[k] - kk; i++) mq[k][i] = mq[k][i + kk];
                mn[k]  = mn[k] - kk;
                mpc[k] = mpc[k] + 32'(2 * kk);
            end
        end
    endtask

    task automatic run_cycle();
        #1;
        eval_k(0);
        eval_k(1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_all();
        rst_s[0] = 1'b0;
        rst_s[1] = 1'b0;
        run_cycle();
        idle_all();
    endtask

    function automatic logic [15:0] rand_hw();
        logic [15:0] h;
        h = 16'($urandom);
        if ($urandom_range(1) == 1) h[1:0] = 2'b11;
        return h;
    endfunction

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(3) == 0) return 32'hFFFF_FFF0 | 32'($urandom_range(15));
        return $urandom;
    endfunction

    initial begin
        n_chk    = 0;
        n_pass   = 0;
        check_en = 0;
        for (int k = 0; k < 2; k++) begin
            mn[k]    = 0;
            mpc[k]   = 32'h0;
            mskip[k] = 0;
            for (int i = 0; i < 32; i++) mq[k][i] = 16'h0;
        end
        idle_all();
        @(posedge clk);
        #1;
        do_reset();
        check_en = 1;

        // Reset state of the 32-bit instance.
        #1;
        check_eq("rst instr_valid", 32'(vld[0]), 32'h0);
        check_eq("rst fetch_ready", 32'(rdy[0]), 32'h1);
        check_eq("rst pc", pco[0], 32'h0);
        check_eq("rst instr", ins[0], 32'h0);
        check_eq("rst compressed", 32'(cmp[0]), 32'h0);

        // One 32-bit instruction, then pop.
        drive(0, 1'b1, 1'b1, 64'h0000_0013, 1'b0, 1'b0, 32'h0);
        run_cycle();
        drive(0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 32'h0);
        #1;
        check_eq("nop valid", 32'(vld[0]), 32'h1);
        check_eq("nop instr", ins[0], 32'h0000_0013);
        check_eq("nop pc", pco[0], 32'h0);
        run_cycle();
        drive(0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 32'h0);
        #1;
        check_eq("nop pc after pop", pco[0], 32'h4);
        run_cycle();

        // Compressed pair in one beat.
        do_reset();
        drive(0, 1'b1, 1'b1, 64'h4501_4501, 1'b0, 1'b0, 32'h0);
        run_cycle();
        drive(0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 32'h0);
        #1;
        check_eq("pair0 instr", ins[0], 32'h0000_4501);
        check_eq("pair0 comp", 32'(cmp[0]), 32'h1);
        check_eq("pair0 pc", pco[0], 32'h0);
        run_cycle();
        #1;
        check_eq("pair1 instr", ins[0], 32'h0000_4501);
        check_eq("pair1 pc", pco[0], 32'h2);
        run_cycle();
        #1;
        check_eq("pair empty valid", 32'(vld[0]), 32'h0);
        run_cycle();

        // 32-bit instruction split across two beats.
        do_reset();
        drive(0, 1'b1, 1'b1, 64'h0013_4501, 1'b0, 1'b0, 32'h0);
        run_cycle();
        drive(0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 32'h0);
        #1;
        check_eq("split c instr", ins[0], 32'h0000_4501);
        run_cycle();
        drive(0, 1'b1, 1'b1, 64'h4501_0000, 1'b1, 1'b0, 32'h0);
        #1;
        check_eq("split held valid", 32'(vld[0]), 32'h0);
        run_cycle();
        drive(0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 32'h0);
        #1;
        check_eq("split instr", ins[0], 32'h0000_0013);
        check_eq("split pc", pco[0], 32'h2);
        check_eq("split comp", 32'(cmp[0]), 32'h0);
        run_cycle();
        #1;
        check_eq("split tail instr", ins[0], 32'h0000_4501);
        check_eq("split tail pc", pco[0], 32'h6);
        run_cycle();

        // Backpressure: an odd occupancy after a branch to offset 2.
        do_reset();
        drive(0, 1'b1, 1'b1, 64'h0013_0013, 1'b1, 1'b1, 32'h2);
        #1;
        check_eq("bp branch valid", 32'(vld[0]), 32'h0);
        check_eq("bp branch ready", 32'(rdy[0]), 32'h0);
        run_cycle();
        for (int c = 0; c < 5; c++) begin
            drive(0, 1'b1, 1'b1, {32'h0, rand_hw(), rand_hw()}, 1'b0, 1'b0, 32'h0);
            #1;
            check_eq($sformatf("bp ready c%0d", c), 32'(rdy[0]), (c < 3) ? 32'h1 : 32'h0);
            run_cycle();
        end
        for (int c = 0; c < 12; c++) begin
            drive(0, 1'b1, 1'b1, {32'h0, rand_hw(), rand_hw()}, 1'b1, 1'b0, 32'h0);
            run_cycle();
        end

        // PC wraps modulo 2^32.
        do_reset();
        drive(0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 32'hFFFF_FFFE);
        run_cycle();
        drive(0, 1'b1, 1'b1, 64'h4501_1234, 1'b0, 1'b0, 32'h0);
        run_cycle();
        drive(0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 32'h0);
        #1;
        check_eq("wrap instr", ins[0], 32'h0000_4501);
        check_eq("wrap pc", pco[0], 32'hFFFF_FFFE);
        run_cycle();
        #1;
        check_eq("wrap pc after", pco[0], 32'h0);
        run_cycle();

        // 64-bit fetch, branch to 0x102 with a push and pop attempted in the branch cycle.
        do_reset();
        drive(1, 1'b1, 1'b1, 64'h0000_0013_0000_0013, 1'b0, 1'b0, 32'h0);
        run_cycle();
        drive(1, 1'b1, 1'b1, 64'h1111_2222_3333_4444, 1'b1, 1'b1, 32'h102);
        #1;
        check_eq("br64 valid", 32'(vld[1]), 32'h0);
        check_eq("br64 ready", 32'(rdy[1]), 32'h0);
        run_cycle();
        drive(1, 1'b1, 1'b1, 64'h0000_0013_4501_BEEF, 1'b0, 1'b0, 32'h0);
        run_cycle();
        drive(1, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 32'h0);
        #1;
        check_eq("br64 c instr", ins[1], 32'h0000_4501);
        check_eq("br64 c pc", pco[1], 32'h102);
        run_cycle();
        #1;
        check_eq("br64 w instr", ins[1], 32'h0000_0013);
        check_eq("br64 w pc", pco[1], 32'h104);
        run_cycle();
        #1;
        check_eq("br64 drained valid", 32'(vld[1]), 32'h0);
        run_cycle();

        // Reset with four halfwords buffered.
        do_reset();
        drive(0, 1'b1, 1'b1, 64'h0000_0013, 1'b0, 1'b0, 32'h0);
        run_cycle();
        run_cycle();
        drive(0, 1'b0, 1'b1, 64'h0000_0013, 1'b1, 1'b0, 32'h0);
        run_cycle();
        drive(0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 32'h0);
        #1;
        check_eq("midrst valid", 32'(vld[0]), 32'h0);
        check_eq("midrst pc", pco[0], 32'h0);
        check_eq("midrst ready", 32'(rdy[0]), 32'h1);
        run_cycle();

`ifdef CV32E40P_ALIGNER_BYPASS_EN
        do_reset();
        drive(0, 1'b1, 1'b1, 64'h0000_0013, 1'b0, 1'b0, 32'h0);
        #1;
        check_eq("bypass valid", 32'(vld[0]), 32'h1);
        check_eq("bypass instr", ins[0], 32'h0000_0013);
        run_cycle();
`endif

        // Randomized traffic on both instances.
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < 2; k++) begin
                drive(k, ($urandom_range(199) != 0), ($urandom_range(9) < 7),
                      {rand_hw(), rand_hw(), rand_hw(), rand_hw()},
                      ($urandom_range(9) < 6), ($urandom_range(24) == 0), rand_addr());
            end
            run_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
